// File: rtl/dcache_flush_sequencer_pkg.sv
// Shared DCache flush-walk types: set/way index typedefs and the flush sequencer phase encoding.
// Default geometry here sets the top-level parameter defaults of dcache_flush_sequencer.
package dcache_flush_sequencer_pkg;

  localparam int unsigned DCacheSetNum = 64;
  localparam int unsigned DCacheWayNum = 2;

  // Way index is at least one bit wide so direct-mapped caches still get a real port.
  function automatic int unsigned way_bits(int unsigned way_num);
    return (way_num > 1) ? $clog2(way_num) : 1;
  endfunction

  localparam int unsigned DCacheIndexBitWidth = $clog2(DCacheSetNum);
  localparam int unsigned DCacheWayBitWidth   = way_bits(DCacheWayNum);

  typedef logic [DCacheIndexBitWidth-1:0] dcache_index_t;
  typedef logic [DCacheWayBitWidth-1:0]   dcache_way_t;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCheck,
    StWriteback,
    StInvalidate,
    StDone,
    StWaitRelease
  } dcache_flush_seq_phase_e;

endpackage

// File: rtl/dcache_flush_line_counter.sv
// Set/way walk counter: way is the fast-moving digit, index the slow one.
// Reusable by any controller that visits every cache line in order.
module dcache_flush_line_counter
  import dcache_flush_sequencer_pkg::*;
#(
  parameter int unsigned SetNum        = DCacheSetNum,
  parameter int unsigned WayNum        = DCacheWayNum,
  parameter int unsigned IndexBitWidth = $clog2(SetNum),
  parameter int unsigned WayBitWidth   = way_bits(WayNum)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [IndexBitWidth-1:0] index_o,
  output logic [WayBitWidth-1:0]   way_o,
  output logic                     last_line_o
);

  localparam logic [IndexBitWidth-1:0] LastIndex = IndexBitWidth'(SetNum - 1);
  localparam logic [WayBitWidth-1:0]   LastWay   = WayBitWidth'(WayNum - 1);

  logic [IndexBitWidth-1:0] index_q, index_d;
  logic [WayBitWidth-1:0]   way_q, way_d;
  logic                     last_way;

  assign last_way = (way_q == LastWay);

  // Wrapping from the last line back to {0,0} falls out of natural index overflow.
  always_comb begin
    index_d = index_q;
    way_d   = way_q;
    if (clr_i) begin
      index_d = '0;
      way_d   = '0;
    end else if (inc_i) begin
      if (last_way) begin
        way_d   = '0;
        index_d = index_q + IndexBitWidth'(1);
      end else begin
        way_d = way_q + WayBitWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      index_q <= '0;
      way_q   <= '0;
    end else begin
      index_q <= index_d;
      way_q   <= way_d;
    end
  end

  assign index_o     = index_q;
  assign way_o       = way_q;
  assign last_line_o = last_way && (index_q == LastIndex);

endmodule

// File: rtl/dcache_flush_sequencer.sv
// Whole-DCache flush: walks every set/way, writes back valid+dirty lines, invalidates each line,
// pulses completion and holds busy until released. Optional RSD_DCACHE_FLUSH_DIRTY_COUNT_EN.
module dcache_flush_sequencer
  import dcache_flush_sequencer_pkg::*;
#(
  parameter int unsigned SetNum        = DCacheSetNum,
  parameter int unsigned WayNum        = DCacheWayNum,
  parameter int unsigned IndexBitWidth = $clog2(SetNum),
  parameter int unsigned WayBitWidth   = way_bits(WayNum)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_req_i,
  output logic                     flush_req_ack_o,
  output logic                     flush_complete_o,
  input  logic                     flush_release_i,
  output logic                     busy_o,
  output logic                     array_read_en_o,
  output logic                     array_write_en_o,
  output logic [IndexBitWidth-1:0] array_index_o,
  output logic [WayBitWidth-1:0]   array_way_o,
  input  logic                     array_valid_i,
  input  logic                     array_dirty_i,
  output logic                     wb_req_o,
  input  logic                     wb_ack_i
`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
  ,
  output logic [IndexBitWidth+WayBitWidth:0] dirty_count_o
`endif
);

  dcache_flush_seq_phase_e state_q, state_d;

  logic accept;
  logic last_line;

  assign accept = (state_q == StIdle) && flush_req_i;

  dcache_flush_line_counter #(
    .SetNum        (SetNum),
    .WayNum        (WayNum),
    .IndexBitWidth (IndexBitWidth),
    .WayBitWidth   (WayBitWidth)
  ) u_line_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (accept),
    .inc_i       (state_q == StInvalidate),
    .index_o     (array_index_o),
    .way_o       (array_way_o),
    .last_line_o (last_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:        if (flush_req_i) state_d = StRead;
      StRead:        state_d = StCheck;
      StCheck:       state_d = (array_valid_i && array_dirty_i) ? StWriteback : StInvalidate;
      StWriteback:   if (wb_ack_i) state_d = StInvalidate;
      StInvalidate:  state_d = last_line ? StDone : StRead;
      StDone:        state_d = StWaitRelease;
      StWaitRelease: if (flush_release_i) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // wb_req is masked by reset so an unacked request is withdrawn in the reset cycle itself.
  always_comb begin
    flush_req_ack_o  = 1'b0;
    flush_complete_o = 1'b0;
    busy_o           = 1'b1;
    array_read_en_o  = 1'b0;
    array_write_en_o = 1'b0;
    wb_req_o         = 1'b0;
    unique case (state_q)
      StIdle: begin
        flush_req_ack_o = 1'b1;
        busy_o          = 1'b0;
      end
      StRead:       array_read_en_o  = 1'b1;
      StWriteback:  wb_req_o         = !rst_i;
      StInvalidate: array_write_en_o = 1'b1;
      StDone:       flush_complete_o = 1'b1;
      default: ;
    endcase
  end

`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
  localparam int unsigned CountWidth = IndexBitWidth + WayBitWidth + 1;

  logic [CountWidth-1:0] dirty_count_q, dirty_count_d;

  always_comb begin
    dirty_count_d = dirty_count_q;
    if (accept) begin
      dirty_count_d = '0;
    end else if ((state_q == StWriteback) && wb_ack_i) begin
      dirty_count_d = dirty_count_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dirty_count_q <= '0;
    end else begin
      dirty_count_q <= dirty_count_d;
    end
  end

  assign dirty_count_o = dirty_count_q;
`endif

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Bench for dcache_flush_sequencer (4 sets x 2 ways): a per-flush expected-activity schedule
// is built from array contents and write-back delays, and checked every cycle.
module tb_dcache_flush_sequencer;

  localparam int unsigned SetNum = 4;
  localparam int unsigned WayNum = 2;
  localparam int unsigned L      = SetNum * WayNum;
  localparam int unsigned IW     = 2;
  localparam int unsigned WW     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush_req;
  logic          flush_release;
  logic          wb_ack = 1'b0;
  logic          array_valid = 1'b0;
  logic          array_dirty = 1'b0;
  logic          flush_req_ack;
  logic          flush_complete;
  logic          busy;
  logic          array_read_en;
  logic          array_write_en;
  logic [IW-1:0] array_index;
  logic [WW-1:0] array_way;
  logic          wb_req;
`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
  logic [IW+WW:0] dirty_count;
`endif

  dcache_flush_sequencer #(
    .SetNum (SetNum),
    .WayNum (WayNum)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_req_i      (flush_req),
    .flush_req_ack_o  (flush_req_ack),
    .flush_complete_o (flush_complete),
    .flush_release_i  (flush_release),
    .busy_o           (busy),
    .array_read_en_o  (array_read_en),
    .array_write_en_o (array_write_en),
    .array_index_o    (array_index),
    .array_way_o      (array_way),
    .array_valid_i    (array_valid),
    .array_dirty_i    (array_dirty),
    .wb_req_o         (wb_req),
    .wb_ack_i         (wb_ack)
`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
    ,
    .dirty_count_o    (dirty_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-owned configuration.
  logic pre_v[L];
  logic pre_d[L];
  int   ack_delay[L];
  logic do_load = 1'b0;
  bit   chk_en  = 1'b0;

  // Tag/status array: one-cycle read latency, invalidate clears valid and dirty.
  logic mem_v[L];
  logic mem_d[L];
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < L; i++) begin
        mem_v[i] <= pre_v[i];
        mem_d[i] <= pre_d[i];
      end
    end else if (array_write_en) begin
      mem_v[int'(array_index) * WayNum + int'(array_way)] <= 1'b0;
      mem_d[int'(array_index) * WayNum + int'(array_way)] <= 1'b0;
    end
    if (array_read_en) begin
      array_valid <= mem_v[int'(array_index) * WayNum + int'(array_way)];
      array_dirty <= mem_d[int'(array_index) * WayNum + int'(array_way)];
    end else begin
      array_valid <= 1'b0;
      array_dirty <= 1'b0;
    end
  end

  // Write-back port: withholds wbAck for ack_delay[line] cycles of a request.
  int wb_wait = 0;
  always @(posedge clk) begin
    #1;
    if (wb_req) begin
      wb_ack = (wb_wait >= ack_delay[int'(array_index) * WayNum + int'(array_way)]);
      wb_wait++;
    end else begin
      wb_ack  = 1'b0;
      wb_wait = 0;
    end
  end

  // Model: one record per expected cycle of a flush, derived from line contents at acceptance.
  typedef struct {
    bit rd;
    bit wr;
    bit wb;
    bit done;
    bit wb_last;
    int idx;
    int way;
  } rec_t;
  typedef enum {MIdle, MRun, MWait} mode_e;

  rec_t  sched[$];
  mode_e mode = MIdle;
  int    exp_dcount = 0;
  int    run_cyc = 0;
  int    comp_cyc = -1;
  int    n_wr = 0;
  int    n_wb = 0;
  bit    done_seen = 1'b0;

  always @(negedge clk) begin
    bit   e_ack, e_busy, e_rd, e_wr, e_wb, e_done, e_pos;
    int   e_idx, e_way, ln;
    rec_t cur, r;
    if (chk_en) begin
      e_ack = 0; e_busy = 1; e_rd = 0; e_wr = 0; e_wb = 0; e_done = 0;
      e_idx = 0; e_way = 0; e_pos = 1;
      cur = '{rd: 0, wr: 0, wb: 0, done: 0, wb_last: 0, idx: 0, way: 0};
      if (mode == MIdle) begin
        e_ack  = 1;
        e_busy = 0;
      end else if (mode == MRun) begin
        run_cyc++;
        cur    = sched[0];
        e_rd   = cur.rd;
        e_wr   = cur.wr;
        e_wb   = cur.wb && !rst;
        e_done = cur.done;
        e_idx  = cur.idx;
        e_way  = cur.way;
        e_pos  = cur.rd || cur.wr || cur.wb;
        if (array_write_en) n_wr++;
        if (wb_req) n_wb++;
        if (flush_complete) begin
          done_seen = 1'b1;
          comp_cyc  = run_cyc;
        end
      end
      chk("flush_req_ack", flush_req_ack, e_ack);
      chk("busy", busy, e_busy);
      chk("array_read_en", array_read_en, e_rd);
      chk("array_write_en", array_write_en, e_wr);
      chk("wb_req", wb_req, e_wb);
      chk("flush_complete", flush_complete, e_done);
      if (e_pos) begin
        chk("array_index", 32'(array_index), e_idx);
        chk("array_way", 32'(array_way), e_way);
      end
`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
      chk("dirty_count", 32'(dirty_count), exp_dcount);
`endif
      if (rst) begin
        mode = MIdle;
        sched.delete();
        exp_dcount = 0;
      end else begin
        case (mode)
          MIdle: if (flush_req) begin
            sched.delete();
            for (int s = 0; s < SetNum; s++) begin
              for (int w = 0; w < WayNum; w++) begin
                ln = s * WayNum + w;
                r = '{rd: 1, wr: 0, wb: 0, done: 0, wb_last: 0, idx: s, way: w};
                sched.push_back(r);
                r.rd = 0;
                sched.push_back(r);
                if (mem_v[ln] && mem_d[ln]) begin
                  for (int k = 0; k <= ack_delay[ln]; k++) begin
                    r.wb      = 1;
                    r.wb_last = (k == ack_delay[ln]);
                    sched.push_back(r);
                  end
                end
                r.wb      = 0;
                r.wb_last = 0;
                r.wr      = 1;
                sched.push_back(r);
              end
            end
            r = '{rd: 0, wr: 0, wb: 0, done: 1, wb_last: 0, idx: 0, way: 0};
            sched.push_back(r);
            mode       = MRun;
            exp_dcount = 0;
            run_cyc    = 0;
            n_wr       = 0;
            n_wb       = 0;
            comp_cyc   = -1;
            done_seen  = 1'b0;
          end
          MRun: begin
            cur = sched.pop_front();
            if (cur.wb_last) exp_dcount++;
            if (cur.done) mode = MWait;
          end
          MWait: if (flush_release) mode = MIdle;
          default: mode = MIdle;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lines(input int vmask, input int dmask);
    for (int i = 0; i < L; i++) begin
      pre_v[i]     = vmask[i];
      pre_d[i]     = dmask[i];
      ack_delay[i] = 0;
    end
    do_load = 1'b1;
    tick();
    do_load = 1'b0;
  endtask

  task automatic start_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (!done_seen && n < max_cycles) begin
      tick();
      n++;
    end
    chk("done_within_budget", done_seen, 1);
  endtask

  task automatic release_flush();
    flush_release = 1'b1;
    tick();
    flush_release = 1'b0;
    @(negedge clk);
    chk("ack_after_release", flush_req_ack, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    flush_req     = 1'b0;
    flush_release = 1'b0;
    for (int i = 0; i < L; i++) begin
      pre_v[i]     = 1'b0;
      pre_d[i]     = 1'b0;
      ack_delay[i] = 0;
    end
    do_load = 1'b1;
    tick();
    tick();
    do_load = 1'b0;
    rst     = 1'b0;
    chk_en  = 1'b1;
    @(negedge clk);
    chk("reset_ack", flush_req_ack, 1);
    chk("reset_busy", busy, 0);
    tick();

    // 1: all lines invalid.
    load_lines(0, 0);
    start_flush();
    wait_done(200);
    chk("t1_complete_cycle", comp_cyc, 25);
    chk("t1_invalidates", n_wr, 8);
    chk("t1_wb_cycles", n_wb, 0);
    release_flush();

    // 2: set 2 way 1 dirty with ack withheld 3 cycles; release coincident with DONE is ignored.
    load_lines(8'b0010_0001, 8'b0010_1000);
    ack_delay[5] = 3;
    start_flush();
    n = 0;
    while (!flush_complete && n < 200) begin
      tick();
      n++;
    end
    flush_release = 1'b1;
    tick();
    flush_release = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("t2_done_seen", done_seen, 1);
    chk("t2_complete_cycle", comp_cyc, 29);
    chk("t2_wb_cycles", n_wb, 4);
    chk("t2_still_busy", busy, 1);
    chk("t2_no_ack", flush_req_ack, 0);
    tick();
    release_flush();

    // 3: all lines dirty, immediate ack; stray flush_req in CHECK and WAIT_RELEASE.
    load_lines(8'hff, 8'hff);
    start_flush();
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_done(200);
    chk("t3_complete_cycle", comp_cyc, 33);
    chk("t3_invalidates", n_wr, 8);
    chk("t3_wb_cycles", n_wb, 8);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_wait_busy", busy, 1);
    chk("t3_wait_no_ack", flush_req_ack, 0);
`ifdef RSD_DCACHE_FLUSH_DIRTY_COUNT_EN
    chk("t3_dirty_count", 32'(dirty_count), 8);
`endif
    tick();
    release_flush();

    // 4: reset during WRITEBACK, then a clean restart from line 0.
    load_lines(8'b0000_0001, 8'b0000_0001);
    ack_delay[0] = 5;
    start_flush();
    n = 0;
    while (!wb_req && n < 50) begin
      tick();
      n++;
    end
    chk("t4_reached_wb", wb_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_ack_after_rst", flush_req_ack, 1);
    chk("t4_busy_after_rst", busy, 0);
    chk("t4_wb_after_rst", wb_req, 0);
    tick();
    ack_delay[0] = 0;
    start_flush();
    wait_done(200);
    chk("t4_complete_cycle", comp_cyc, 26);
    chk("t4_wb_cycles", n_wb, 1);
    release_flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
